multi_func_alu_unit: RTL and testbench

//  Switch-driven 8-bit ALU for the board demo.
//  - data_SW picks an (A,B) operand pair from a fixed table; OP picks the operation.
//  - LED_SW picks what the 8 LEDs show: result, operands, flags or test patterns.
//  - Leaf block between the board switch inputs and the LED pins; fully synchronous, 2-stage.

---
 rtl/multi_func_alu_pkg.sv | 40 ++++
 rtl/multi_func_alu_core.sv | 67 ++++++
 rtl/multi_func_alu_unit.sv | 79 +++++++
 tb/tb_multi_func_alu_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_func_alu_pkg.sv
// Shared encodings, operand table and LED flag layout for the switch-driven demo ALU.
// Optional saturating arithmetic is enabled by defining MULTI_FUNC_ALU_SAT_EN.
package multi_func_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        DISP_RESULT  = 3'd0,
        DISP_A       = 3'd1,
        DISP_B       = 3'd2,
        DISP_FLAGS   = 3'd3,
        DISP_NIBBLES = 3'd4,
        DISP_INV     = 3'd5,
        DISP_OFF     = 3'd6,
        DISP_LAMP    = 3'd7
    } disp_e;

    // Entry k of each table occupies bits [8k+7:8k].
    localparam logic [63:0] OPERAND_A_TABLE = {8'h3C, 8'hAA, 8'h80, 8'hFF, 8'h7F, 8'h0F, 8'h01, 8'h00};
    localparam logic [63:0] OPERAND_B_TABLE = {8'hF0, 8'h55, 8'h80, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};

    localparam int FLAG_Z = 7;
    localparam int FLAG_C = 6;
    localparam int FLAG_V = 5;
    localparam int FLAG_N = 4;

    function automatic logic [7:0] tableEntry(input logic [63:0] tbl, input logic [2:0] k);
        return tbl[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/multi_func_alu_core.sv
// Combinational 8-bit ALU: (A,B,OP) -> (R,Z,C,V,N).
// Defining MULTI_FUNC_ALU_SAT_EN makes ADD/SUB saturate instead of wrapping.
module multi_func_alu_core
    import multi_func_alu_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  op_e        op_i,
    output logic [7:0] r_o,
    output logic       z_o,
    output logic       c_o,
    output logic       v_o,
    output logic       n_o
);

    logic [8:0] wide;
    logic [7:0] raw;

    // Carry and overflow always come from the unclamped result.
    always_comb begin
        wide = '0;
        raw  = '0;
        c_o  = 1'b0;
        v_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                wide = {1'b0, a_i} + {1'b0, b_i};
                raw  = wide[7:0];
                c_o  = wide[8];
                v_o  = (a_i[7] == b_i[7]) && (raw[7] != a_i[7]);
            end
            OP_SUB: begin
                wide = {1'b0, a_i} - {1'b0, b_i};
                raw  = wide[7:0];
                c_o  = wide[8];
                v_o  = (a_i[7] != b_i[7]) && (raw[7] != a_i[7]);
            end
            OP_AND:  raw = a_i & b_i;
            OP_OR:   raw = a_i | b_i;
            OP_XOR:  raw = a_i ^ b_i;
            OP_NOT:  raw = ~a_i;
            OP_SHL: begin
                raw = {a_i[6:0], 1'b0};
                c_o = a_i[7];
            end
            OP_SHR: begin
                raw = {1'b0, a_i[7:1]};
                c_o = a_i[0];
            end
            default: raw = '0;
        endcase
    end

    always_comb begin
        r_o = raw;
`ifdef MULTI_FUNC_ALU_SAT_EN
        if (c_o && (op_i == OP_ADD)) begin
            r_o = 8'hFF;
        end else if (c_o && (op_i == OP_SUB)) begin
            r_o = 8'h00;
        end
`endif
        z_o = (r_o == 8'h00);
        n_o = r_o[7];
    end

endmodule

// File: rtl/multi_func_alu_unit.sv
// Two-stage switch-to-LED ALU demo: stage 1 registers the switches, stage 2 registers the LEDs.
// Optional saturating ADD/SUB is enabled by defining MULTI_FUNC_ALU_SAT_EN.
module multi_func_alu_unit
    import multi_func_alu_pkg::*;
(
    input  logic       MULTI_FUNC_ALU_UNIT_clk_xi,
    input  logic       MULTI_FUNC_ALU_UNIT_rst_n_xi,
    input  logic [2:0] MULTI_FUNC_ALU_UNIT_OP_xi,
    input  logic [2:0] MULTI_FUNC_ALU_UNIT_data_SW_xi,
    input  logic [2:0] MULTI_FUNC_ALU_UNIT_LED_SW_xi,
    output logic [7:0] MULTI_FUNC_ALU_UNIT_LED_xo
);

    op_e        op_q;
    logic [2:0] dataSel_q;
    disp_e      ledSel_q;
    logic [7:0] led_q;
    logic [7:0] led_d;

    logic [7:0] opA;
    logic [7:0] opB;
    logic [7:0] result;
    logic       flagZ;
    logic       flagC;
    logic       flagV;
    logic       flagN;

    always_ff @(posedge MULTI_FUNC_ALU_UNIT_clk_xi or negedge MULTI_FUNC_ALU_UNIT_rst_n_xi) begin
        if (!MULTI_FUNC_ALU_UNIT_rst_n_xi) begin
            op_q      <= OP_ADD;
            dataSel_q <= '0;
            ledSel_q  <= DISP_RESULT;
            led_q     <= '0;
        end else begin
            op_q      <= op_e'(MULTI_FUNC_ALU_UNIT_OP_xi);
            dataSel_q <= MULTI_FUNC_ALU_UNIT_data_SW_xi;
            ledSel_q  <= disp_e'(MULTI_FUNC_ALU_UNIT_LED_SW_xi);
            led_q     <= led_d;
        end
    end

    assign opA = tableEntry(OPERAND_A_TABLE, dataSel_q);
    assign opB = tableEntry(OPERAND_B_TABLE, dataSel_q);

    multi_func_alu_core u_core (
        .a_i  (opA),
        .b_i  (opB),
        .op_i (op_q),
        .r_o  (result),
        .z_o  (flagZ),
        .c_o  (flagC),
        .v_o  (flagV),
        .n_o  (flagN)
    );

    always_comb begin
        led_d = '0;
        case (ledSel_q)
            DISP_RESULT:  led_d = result;
            DISP_A:       led_d = opA;
            DISP_B:       led_d = opB;
            DISP_FLAGS: begin
                led_d[FLAG_Z] = flagZ;
                led_d[FLAG_C] = flagC;
                led_d[FLAG_V] = flagV;
                led_d[FLAG_N] = flagN;
                led_d[2:0]    = op_q;
            end
            DISP_NIBBLES: led_d = {opA[3:0], opB[3:0]};
            DISP_INV:     led_d = ~result;
            DISP_OFF:     led_d = 8'h00;
            DISP_LAMP:    led_d = 8'hFF;
            default:      led_d = 8'h00;
        endcase
    end

    assign MULTI_FUNC_ALU_UNIT_LED_xo = led_q;

endmodule

// File: tb/tb_multi_func_alu_unit.sv
// Scoreboard bench for multi_func_alu_unit: directed vectors plus random switches against a reference model.
// Define MULTI_FUNC_ALU_SAT_EN for both bench and RTL to check the saturating build.
module tb_multi_func_alu_unit;

    logic       clk;
    logic       rstN;
    logic [2:0] opSw;
    logic [2:0] dataSw;
    logic [2:0] ledSw;
    logic [7:0] led;

    int tests;
    int fails;
    int cycleCnt;
    bit monitorOn;

    typedef struct {
        logic [7:0] expected;
        int         due;
        string      name;
    } item_t;

    item_t sbQ[$];

    logic [7:0] tblA [0:7] = '{8'h00, 8'h01, 8'h0F, 8'h7F, 8'hFF, 8'h80, 8'hAA, 8'h3C};
    logic [7:0] tblB [0:7] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h80, 8'h55, 8'hF0};

    multi_func_alu_unit dut (
        .MULTI_FUNC_ALU_UNIT_clk_xi     (clk),
        .MULTI_FUNC_ALU_UNIT_rst_n_xi   (rstN),
        .MULTI_FUNC_ALU_UNIT_OP_xi      (opSw),
        .MULTI_FUNC_ALU_UNIT_data_SW_xi (dataSw),
        .MULTI_FUNC_ALU_UNIT_LED_SW_xi  (ledSw),
        .MULTI_FUNC_ALU_UNIT_LED_xo     (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Reference model: integer arithmetic over the operation and display rules.
    function automatic logic [7:0] refModel(input int op, input int k, input int ls);
        int a, b, sa, sb, res, r, c, v, z, n, disp;
        a  = int'(tblA[k]);
        b  = int'(tblB[k]);
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        c  = 0;
        v  = 0;
        r  = 0;
        case (op)
            0: begin
                res = a + b;
                r   = res % 256;
                c   = (res > 255) ? 1 : 0;
                v   = ((sa + sb > 127) || (sa + sb < -128)) ? 1 : 0;
`ifdef MULTI_FUNC_ALU_SAT_EN
                if (c == 1) r = 255;
`endif
            end
            1: begin
                res = a - b;
                r   = (res + 256) % 256;
                c   = (a < b) ? 1 : 0;
                v   = ((sa - sb > 127) || (sa - sb < -128)) ? 1 : 0;
`ifdef MULTI_FUNC_ALU_SAT_EN
                if (c == 1) r = 0;
`endif
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin
                r = (a * 2) % 256;
                c = (a >= 128) ? 1 : 0;
            end
            default: begin
                r = a / 2;
                c = a % 2;
            end
        endcase
        z = (r == 0) ? 1 : 0;
        n = (r >= 128) ? 1 : 0;
        case (ls)
            0: disp = r;
            1: disp = a;
            2: disp = b;
            3: disp = z * 128 + c * 64 + v * 32 + n * 16 + op;
            4: disp = (a % 16) * 16 + (b % 16);
            5: disp = 255 - r;
            6: disp = 0;
            default: disp = 255;
        endcase
        return 8'(disp);
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: LED=%02h expected %02h", name, actual, expected);
        end
    endtask

    // Drive one switch setting just before a rising edge and queue what the LEDs must show two edges later.
    task automatic applyStimulus(input int op, input int k, input int ls, input logic [7:0] expected, input string name);
        item_t it;
        @(negedge clk);
        opSw   = 3'(op);
        dataSw = 3'(k);
        ledSw  = 3'(ls);
        it.expected = expected;
        it.due      = cycleCnt + 2;
        it.name     = name;
        sbQ.push_back(it);
    endtask

    initial begin
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (monitorOn) begin
                while (sbQ.size() > 0 && sbQ[0].due <= cycleCnt) begin
                    it = sbQ.pop_front();
                    checkOutput(it.name, led, it.expected);
                end
            end
        end
    end

    initial begin
        int op, k, ls;
        logic [7:0] satAddFlags;
        tests     = 0;
        fails     = 0;
        cycleCnt  = 0;
        monitorOn = 1'b0;
        rstN      = 1'b1;
        opSw      = 3'd5;
        dataSw    = 3'd0;
        ledSw     = 3'd0;

        #2 rstN = 1'b0;
        #1 checkOutput("reset_async", led, 8'h00);
        repeat (3) @(posedge clk);
        #1 checkOutput("reset_held", led, 8'h00);

        @(negedge clk);
        opSw   = 3'd0;
        dataSw = 3'd0;
        ledSw  = 3'd0;
        rstN   = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 checkOutput("release_zero", led, 8'h00);
        end

`ifdef MULTI_FUNC_ALU_SAT_EN
        satAddFlags = 8'h50;
`else
        satAddFlags = 8'hC0;
`endif
        monitorOn = 1'b1;
        applyStimulus(0, 1, 0, 8'h02, "add_1_1");
        applyStimulus(5, 0, 0, 8'hFF, "not_0");
        applyStimulus(0, 3, 3, 8'h30, "add_ovf_flags");
        applyStimulus(0, 4, 3, satAddFlags, "add_carry_flags");
        applyStimulus(1, 5, 3, 8'h81, "sub_zero_flags");
        applyStimulus(1, 1, 3, 8'h81, "sub_1_1_flags");
        applyStimulus(6, 6, 0, 8'h54, "shl_aa");
        applyStimulus(6, 6, 3, 8'h46, "shl_aa_flags");
        applyStimulus(7, 6, 0, 8'h55, "shr_aa");
        applyStimulus(7, 7, 4, 8'hC0, "nibbles_7");
        applyStimulus(7, 7, 7, 8'hFF, "lamp");
        applyStimulus(0, 6, 1, 8'hAA, "show_a");
        applyStimulus(0, 6, 2, 8'h55, "show_b");
        applyStimulus(2, 6, 5, 8'hFF, "inv_and");
        applyStimulus(4, 7, 6, 8'h00, "off");

        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(7, 0));
            k  = int'($urandom_range(7, 0));
            ls = int'($urandom_range(7, 0));
            applyStimulus(op, k, ls, refModel(op, k, ls), "random");
        end

        for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(posedge clk);
        #2;
        tests++;
        if (sbQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: %0d entries left expected 0", sbQ.size());
        end
        monitorOn = 1'b0;
        sbQ.delete();

        @(negedge clk);
        opSw   = 3'd0;
        dataSw = 3'd6;
        ledSw  = 3'd0;
        repeat (2) @(posedge clk);
        #1 checkOutput("latency_setup", led, 8'hFF);
        @(negedge clk);
        ledSw = 3'd1;
        @(posedge clk);
        #1 checkOutput("latency_early", led, 8'hFF);
        @(posedge clk);
        #1 checkOutput("latency_arrive", led, 8'hAA);

        #2 rstN = 1'b0;
        #1 checkOutput("reset_midrun", led, 8'h00);
        @(negedge clk);
        opSw   = 3'd2;
        dataSw = 3'd6;
        ledSw  = 3'd1;
        rstN   = 1'b1;
        @(posedge clk);
        #1 checkOutput("release_edge1", led, 8'h00);
        @(posedge clk);
        #1 checkOutput("release_edge2", led, 8'hAA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
